// File: rtl/gowin_dpb_ram_if.sv
// Bundled port A / port B signals of the true dual-port block RAM.
// The bus master drives addresses, data and enables; the RAM returns douta/doutb.
interface gowin_dpb_ram_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16
);
    logic                  cea;
    logic                  wrea;
    logic [ADDR_WIDTH-1:0] ada;
    logic [DATA_WIDTH-1:0] dina;
    logic                  ocea;
    logic [DATA_WIDTH-1:0] douta;

    logic                  ceb;
    logic                  wreb;
    logic [ADDR_WIDTH-1:0] adb;
    logic [DATA_WIDTH-1:0] dinb;
    logic                  oceb;
    logic [DATA_WIDTH-1:0] doutb;

    modport master (
        output cea, wrea, ada, dina, ocea,
        output ceb, wreb, adb, dinb, oceb,
        input  douta, doutb
    );

    modport slave (
        input  cea, wrea, ada, dina, ocea,
        input  ceb, wreb, adb, dinb, oceb,
        output douta, doutb
    );
endinterface

// File: rtl/gowin_dpb_ram.sv
// True dual-port block RAM, one clock. Define DPB_OUT_REG_EN to add an ocea/oceb-gated
// output register per port (read latency 2); otherwise dout comes straight from the read latch.
module gowin_dpb_ram #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16
) (
    input  logic              clka,
    input  logic              reseta,
    gowin_dpb_ram_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Index 0 is port A, index 1 is port B.
    logic                  w_ce   [2];
    logic                  w_we   [2];
    logic                  w_oce  [2];
    logic [ADDR_WIDTH-1:0] w_ad   [2];
    logic [DATA_WIDTH-1:0] w_din  [2];
    logic [DATA_WIDTH-1:0] w_dout [2];

    assign w_ce[0]  = bus.cea;
    assign w_we[0]  = bus.wrea;
    assign w_oce[0] = bus.ocea;
    assign w_ad[0]  = bus.ada;
    assign w_din[0] = bus.dina;
    assign w_ce[1]  = bus.ceb;
    assign w_we[1]  = bus.wreb;
    assign w_oce[1] = bus.oceb;
    assign w_ad[1]  = bus.adb;
    assign w_din[1] = bus.dinb;

    assign bus.douta = w_dout[0];
    assign bus.doutb = w_dout[1];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Port B is applied last so it wins a same-address write collision.
    // The array has no reset: writes during reset still commit.
    always_ff @(posedge clka) begin
        for (int p = 0; p < 2; p++) begin
            if (w_ce[p] && w_we[p]) begin
                r_mem[w_ad[p]] <= w_din[p];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_WIDTH-1:0] r_lat;

            // Non-blocking read of r_mem yields old data when the other port writes.
            always_ff @(posedge clka) begin
                if (reseta) begin
                    r_lat <= '0;
                end else if (w_ce[gi] && !w_we[gi]) begin
                    r_lat <= r_mem[w_ad[gi]];
                end
            end

`ifdef DPB_OUT_REG_EN
            logic [DATA_WIDTH-1:0] r_out;

            always_ff @(posedge clka) begin
                if (reseta) begin
                    r_out <= '0;
                end else if (w_oce[gi]) begin
                    r_out <= r_lat;
                end
            end

            assign w_dout[gi] = r_out;
`else
            assign w_dout[gi] = r_lat;
`endif
        end
    endgenerate

`ifndef DPB_OUT_REG_EN
    wire w_unused_oce = w_oce[0] | w_oce[1];
`endif
endmodule

// File: tb/tb_gowin_dpb_ram.sv
// Directed self-checking bench for gowin_dpb_ram: vector table plus hand-written
// sequences for pipelining, enables and reset during a read.
module tb_gowin_dpb_ram;
`ifdef DPB_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    gowin_dpb_ram_if #(.ADDR_WIDTH(7), .DATA_WIDTH(16)) bus ();

    gowin_dpb_ram #(.ADDR_WIDTH(7), .DATA_WIDTH(16)) dut (
        .clka   (clk),
        .reseta (rst),
        .bus    (bus)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        cea;
        logic        wrea;
        logic [6:0]  ada;
        logic [15:0] dina;
        logic        ceb;
        logic        wreb;
        logic [6:0]  adb;
        logic [15:0] dinb;
        logic        chk_a;
        logic [15:0] exp_a;
        logic        chk_b;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%04h", name, act);
        end
    endtask

    task automatic add_vec(input string name, input logic r,
                           input logic cea, input logic wrea, input logic [6:0] ada, input logic [15:0] dina,
                           input logic ceb, input logic wreb, input logic [6:0] adb, input logic [15:0] dinb,
                           input logic chk_a, input logic [15:0] exp_a,
                           input logic chk_b, input logic [15:0] exp_b);
        vec_t v;
        v.name = name; v.rst = r;
        v.cea = cea; v.wrea = wrea; v.ada = ada; v.dina = dina;
        v.ceb = ceb; v.wreb = wreb; v.adb = adb; v.dinb = dinb;
        v.chk_a = chk_a; v.exp_a = exp_a; v.chk_b = chk_b; v.exp_b = exp_b;
        vecs.push_back(v);
    endtask

    task automatic idle();
        bus.cea = 1'b0; bus.wrea = 1'b0;
        bus.ceb = 1'b0; bus.wreb = 1'b0;
    endtask

    // One operation, then (with the output register) one idle edge to move the latch out.
    task automatic apply_vec(input vec_t v);
        rst = v.rst;
        bus.cea = v.cea; bus.wrea = v.wrea; bus.ada = v.ada; bus.dina = v.dina;
        bus.ceb = v.ceb; bus.wreb = v.wreb; bus.adb = v.adb; bus.dinb = v.dinb;
        bus.ocea = 1'b1; bus.oceb = 1'b1;
        tick();
        if (LAT == 2) begin
            idle();
            tick();
        end
        if (v.chk_a) check({v.name, "/douta"}, bus.douta, v.exp_a);
        if (v.chk_b) check({v.name, "/doutb"}, bus.doutb, v.exp_b);
    endtask

    logic [6:0]  pipe_addr [4];
    logic        pipe_rd   [4];
    logic [15:0] pipe_exp1 [4];
    logic [15:0] pipe_exp2 [4];

    initial begin
        idle();
        bus.ada = '0; bus.dina = '0; bus.adb = '0; bus.dinb = '0;
        bus.ocea = 1'b1; bus.oceb = 1'b1;

        //       name         rst  cea wa  ada    dina      ceb wb  adb    dinb      chkA expA      chkB expB
        add_vec("reset1",     1,   1,  0,  7'h00, 16'h0000, 1,  0,  7'h00, 16'h0000, 1,   16'h0000, 1,   16'h0000);
        add_vec("reset2",     1,   1,  0,  7'h00, 16'h0000, 1,  0,  7'h00, 16'h0000, 1,   16'h0000, 1,   16'h0000);
        add_vec("rd_pwrup",   0,   1,  0,  7'h05, 16'h0000, 1,  0,  7'h05, 16'h0000, 1,   16'h0000, 1,   16'h0000);
        add_vec("a_wr_12",    0,   1,  1,  7'h12, 16'hBEEF, 0,  0,  7'h00, 16'h0000, 1,   16'h0000, 1,   16'h0000);
        add_vec("b_rd_12",    0,   0,  0,  7'h00, 16'h0000, 1,  0,  7'h12, 16'h0000, 1,   16'h0000, 1,   16'hBEEF);
        add_vec("coll_wr_7f", 0,   1,  1,  7'h7F, 16'h1111, 1,  1,  7'h7F, 16'h2222, 1,   16'h0000, 1,   16'hBEEF);
        add_vec("rd_7f",      0,   1,  0,  7'h7F, 16'h0000, 1,  0,  7'h7F, 16'h0000, 1,   16'h2222, 1,   16'h2222);
        add_vec("a_wr_20",    0,   1,  1,  7'h20, 16'h00AA, 0,  0,  7'h00, 16'h0000, 1,   16'h2222, 0,   16'h0000);
        add_vec("rdw_20",     0,   1,  0,  7'h20, 16'h0000, 1,  1,  7'h20, 16'h00BB, 1,   16'h00AA, 1,   16'h2222);
        add_vec("a_rd_20",    0,   1,  0,  7'h20, 16'h0000, 0,  0,  7'h00, 16'h0000, 1,   16'h00BB, 0,   16'h0000);
        add_vec("a_rd_12",    0,   1,  0,  7'h12, 16'h0000, 1,  0,  7'h05, 16'h0000, 1,   16'hBEEF, 1,   16'h0000);

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);
        rst = 1'b0;

        // Back-to-back reads on port A; douta starts at 0xBEEF.
        pipe_addr[0] = 7'h7F; pipe_rd[0] = 1; pipe_exp1[0] = 16'h2222; pipe_exp2[0] = 16'hBEEF;
        pipe_addr[1] = 7'h12; pipe_rd[1] = 1; pipe_exp1[1] = 16'hBEEF; pipe_exp2[1] = 16'h2222;
        pipe_addr[2] = 7'h20; pipe_rd[2] = 1; pipe_exp1[2] = 16'h00BB; pipe_exp2[2] = 16'hBEEF;
        pipe_addr[3] = 7'h00; pipe_rd[3] = 0; pipe_exp1[3] = 16'h00BB; pipe_exp2[3] = 16'h00BB;
        for (int i = 0; i < 4; i++) begin
            bus.cea = pipe_rd[i]; bus.wrea = 1'b0; bus.ada = pipe_addr[i];
            tick();
            check($sformatf("pipe%0d", i), bus.douta, (LAT == 2) ? pipe_exp2[i] : pipe_exp1[i]);
        end

        // Write then immediate read of the same address on port A.
        bus.cea = 1; bus.wrea = 1; bus.ada = 7'h33; bus.dina = 16'h1234;
        tick();
        bus.wrea = 0;
        tick();
        idle();
        if (LAT == 2) tick();
        check("wr_then_rd_33", bus.douta, 16'h1234);

        // Output-register enable and clock enable.
        bus.cea = 1; bus.ada = 7'h12;
        tick();
        idle();
        if (LAT == 2) tick();
        check("en_rd_12", bus.douta, 16'hBEEF);
        bus.ocea = 0; bus.cea = 1; bus.ada = 7'h20;
        tick();
        idle();
        tick();
        check("oce_low_hold", bus.douta, (LAT == 2) ? 16'hBEEF : 16'h00BB);
        bus.ocea = 1;
        tick();
        check("oce_high", bus.douta, 16'h00BB);
        bus.ada = 7'h7F;
        tick();
        tick();
        check("ce_low_hold", bus.douta, 16'h00BB);

        // Reset lands right after a read is issued; a B write in the reset cycle still commits.
        bus.cea = 1; bus.ada = 7'h12;
        tick();
        rst = 1; bus.cea = 0;
        bus.ceb = 1; bus.wreb = 1; bus.adb = 7'h44; bus.dinb = 16'h5A5A;
        tick();
        check("rst_mid_a", bus.douta, 16'h0000);
        check("rst_mid_b", bus.doutb, 16'h0000);
        rst = 0;
        idle();
        tick();
        check("rst_discard_a", bus.douta, 16'h0000);
        bus.cea = 1; bus.ada = 7'h12;
        bus.ceb = 1; bus.wreb = 0; bus.adb = 7'h44;
        tick();
        idle();
        if (LAT == 2) tick();
        check("post_rst_rd_12", bus.douta, 16'hBEEF);
        check("post_rst_rd_44", bus.doutb, 16'h5A5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
